// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pkg : state encoding, ALU opcodes and default widths (rev 1.0)     |
// +-----------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 6;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [OP_W_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W_DEF-1:0] OP_AND = 6'h24;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W_DEF-1:0] OP_NOR = 6'h27;

endpackage
`default_nettype wire

// File: rtl/alu_frontend_timeout.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_frontend_timeout : inter-byte timeout counter (rev 1.0)            |
// +-----------------------------------------------------------------------+
module alu_frontend_timeout #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // A byte arriving on the terminal count wins over the timeout.
  assign expire = run && !clear && (cnt == TERMINAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_uart_frontend.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_uart_frontend : RX byte frame -> ALU operands -> TX result (rev 1.0)|
// | Optional inter-byte timeout and frame_err port: ALU_FRONTEND_TIMEOUT_EN |
// +-----------------------------------------------------------------------+
module alu_uart_frontend
  import alu_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int OP_W           = OP_W_DEF,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
`ifdef ALU_FRONTEND_TIMEOUT_EN
  output logic              frame_err,
`endif
  output logic              rx_drop
);

  state_t state, state_nxt;
  logic   timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GET_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    case (state)
      GET_A:  if (rx_valid) state_nxt = GET_B;
      GET_B: begin
        if (rx_valid)     state_nxt = GET_OP;
        else if (timeout) state_nxt = GET_A;
      end
      GET_OP: begin
        if (rx_valid)     state_nxt = EXEC;
        else if (timeout) state_nxt = GET_A;
      end
      EXEC:   state_nxt = SEND;
      SEND: begin
        if (tx_ready) begin
          tx_start  = 1'b1;
          state_nxt = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase
  end

  assign busy    = (state == EXEC) || (state == SEND);
  // Bytes are never queued while a result is outstanding.
  assign rx_drop = rx_valid && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
    end else begin
      if (rx_valid) begin
        case (state)
          GET_A:   alu_a  <= rx_data;
          GET_B:   alu_b  <= rx_data;
          GET_OP:  alu_op <= rx_data[OP_W-1:0];
          default: ;
        endcase
      end
      if (state == EXEC) begin
        tx_data <= alu_result;
      end
    end
  end

`ifdef ALU_FRONTEND_TIMEOUT_EN
  alu_frontend_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    ((state == GET_B) || (state == GET_OP)),
    .clear  (rx_valid),
    .expire (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;

  // TIMEOUT_CYCLES only sizes the counter in the timeout build.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_frontend.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_uart_frontend : scoreboard bench for alu_uart_frontend (rev 1.0)|
// +-----------------------------------------------------------------------+
module tb_alu_uart_frontend;
  import alu_pkg::*;

  localparam int DATA_W = 8;
  localparam int OP_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] alu_a, alu_b, tx_data;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              tx_ready = 1'b1;
  logic              tx_start, busy, rx_drop;
`ifdef ALU_FRONTEND_TIMEOUT_EN
  logic              frame_err;
`endif

  alu_uart_frontend #(
    .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
`ifdef ALU_FRONTEND_TIMEOUT_EN
    .frame_err(frame_err),
`endif
    .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU that the front end feeds.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SRL:  alu_result = alu_a >> alu_b;
      OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b);
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   starts = 0;
  int   frames_sent = 0;
  int   ferr_seen = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected frame per tx_start.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      starts++;
      check("tx_start_single_cycle", 32'(prev_start), 32'd0);
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.res));
        check("alu_a", 32'(alu_a), 32'(e.a));
        check("alu_b", 32'(alu_b), 32'(e.b));
        check("alu_op", 32'(alu_op), 32'(e.op));
      end
    end
    prev_start = tx_start;
`ifdef ALU_FRONTEND_TIMEOUT_EN
    if (frame_err) ferr_seen++;
`endif
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input logic [5:0] exp_op, input logic [7:0] res);
    exp_t e;
    e.a = a; e.b = b; e.op = exp_op; e.res = res;
    sb.push_back(e);
    frames_sent++;
    send_byte(a);
    send_byte(b);
    send_byte(opb);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rx_drop"}, 32'(rx_drop), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD with exact latency: EXEC cycle then tx_start in SEND.
    frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
    @(negedge clk);
    check("add_exec_busy", 32'(busy), 32'd1);
    check("add_exec_no_start", 32'(tx_start), 32'd0);
    check("add_alu_a", 32'(alu_a), 32'h05);
    @(negedge clk);
    check("add_latency_start", 32'(tx_start), 32'd1);
    repeat (3) @(posedge clk);

    // SUB wrap, then same with upper opcode bits set.
    frame(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
    repeat (3) @(posedge clk);
    frame(8'h03, 8'h05, 8'hE2, 6'h22, 8'hFE);
    // Byte during the SEND->GET_A cycle is dropped.
    @(posedge clk); #1;
    rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge clk);
    check("send_exit_drop", 32'(rx_drop), 32'd1);
    check("send_exit_start", 32'(tx_start), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);

    // Backpressure holds SEND; a byte in SEND is dropped.
    tx_ready = 1'b0;
    frame(8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_no_start", 32'(tx_start), 32'd0);
      check("bp_tx_data", 32'(tx_data), 32'hFF);
      @(posedge clk);
    end
    #1;
    rx_data = 8'hAA; rx_valid = 1'b1;
    @(negedge clk);
    check("drop_pulse", 32'(rx_drop), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = '0;
    @(negedge clk);
    check("drop_one_cycle", 32'(rx_drop), 32'd0);
    check("bp_still_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_release_start", 32'(tx_start), 32'd1);
    @(negedge clk);
    check("bp_idle_after", 32'(busy), 32'd0);
    frame(8'h01, 8'h01, 8'h26, 6'h26, 8'h00);
    repeat (3) @(posedge clk);

    // Reset mid-frame discards the partial frame.
    send_byte(8'h11);
    send_byte(8'h22);
    check("pre_reset_alu_a", 32'(alu_a), 32'h11);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame(8'h08, 8'h02, 8'h02, 6'h02, 8'h02);
    repeat (3) @(posedge clk);

`ifdef ALU_FRONTEND_TIMEOUT_EN
    ferr_seen = 0;
    send_byte(8'h07);
    repeat (19) @(negedge clk);
    check("timeout_frame_err", 32'(ferr_seen), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    frame(8'h04, 8'h04, 8'h20, 6'h20, 8'h08);
    repeat (3) @(posedge clk);
`endif

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("tx_start_count", 32'(starts), 32'(frames_sent));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
